// File: rtl/alu_stack_sequencer_pkg.sv
// Shared ALU opcode, stack command and sequencer state encodings for the
// stack processor's ALU initiator.
package alu_defs;

   localparam logic [3:0] ALU_ADD      = 4'd0;
   localparam logic [3:0] ALU_SUB      = 4'd1;
   localparam logic [3:0] ALU_AND      = 4'd2;
   localparam logic [3:0] ALU_OR       = 4'd3;
   localparam logic [3:0] ALU_XOR      = 4'd4;
   localparam logic [3:0] ALU_SELA     = 4'd5;
   localparam logic [3:0] ALU_SELB     = 4'd6;
   localparam logic [3:0] ALU_NEQ      = 4'd7;
   localparam logic [3:0] ALU_NZA      = 4'd8;
   localparam logic [3:0] ALU_BLTA     = 4'd9;
   localparam logic [3:0] ALU_OPER_MAX = 4'b1001;

   typedef logic [1:0] cmd_op_t;
   localparam cmd_op_t CMD_PUSH = 2'b00;
   localparam cmd_op_t CMD_POP  = 2'b01;
   localparam cmd_op_t CMD_OP   = 2'b10;
   localparam cmd_op_t CMD_NOP  = 2'b11;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_EXEC = 2'd1;
   localparam state_t ST_WB   = 2'd2;

   function automatic logic oper_supported(input logic [3:0] oper);
      return oper <= ALU_OPER_MAX;
   endfunction

endpackage

// File: rtl/alu_stack_sequencer_stack_regfile.sv
// Operand stack storage: DEPTH x WIDTH flops, one synchronous write port and
// two asynchronous read ports (top and next-of-top).
module stack_regfile #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_a_i,
   input  logic [AW-1:0]    raddr_b_i,
   output logic [WIDTH-1:0] rdata_a_o,
   output logic [WIDTH-1:0] rdata_b_o
);

   localparam int AWP = AW + 1;
   localparam logic [AW:0] DEPTH_W = AWP'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Addresses past DEPTH only occur for non-power-of-two depths; they are ignored.
   always_ff @(posedge clk_i) begin
      if (we_i && ({1'b0, waddr_i} < DEPTH_W)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = ({1'b0, raddr_a_i} < DEPTH_W) ? mem_q[raddr_a_i] : '0;
   assign rdata_b_o = ({1'b0, raddr_b_i} < DEPTH_W) ? mem_q[raddr_b_i] : '0;

endmodule

// File: rtl/alu_stack_sequencer.sv
// Stack-processor ALU initiator: owns the operand stack, sequences PUSH/POP/OP
// commands and drives an external combinational ALU with NOS/TOS operands.
module alu_stack_sequencer
   import alu_defs::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   localparam int SP_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [3:0]       cmd_oper,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [3:0]       alu_oper,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_ovf,
   output logic [WIDTH-1:0] tos,
   output logic [SP_W-1:0]  depth,
   output logic             done,
   output logic             err,
   output logic             ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
   localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
   localparam logic [SP_W-1:0] SP_TWO  = SP_W'(2);

   state_t           state_q, state_d;
   logic [SP_W-1:0]  sp_q, sp_d;
   logic [3:0]       alu_oper_q, alu_oper_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             ovf_n_q, ovf_n_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic [AW-1:0]    addr_tos;
   logic [AW-1:0]    addr_nos;
   logic [WIDTH-1:0] rd_tos;
   logic [WIDTH-1:0] rd_nos;
   logic             accept;

   assign addr_tos = AW'(sp_q - SP_ONE);
   assign addr_nos = AW'(sp_q - SP_TWO);

   stack_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk_i     (clk),
      .we_i      (we),
      .waddr_i   (waddr),
      .wdata_i   (wdata),
      .raddr_a_i (addr_tos),
      .raddr_b_i (addr_nos),
      .rdata_a_o (rd_tos),
      .rdata_b_o (rd_nos)
   );

   assign cmd_ready = (state_q == ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      alu_oper_d = alu_oper_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      res_d      = res_q;
      ovf_n_d    = ovf_n_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      we         = 1'b0;
      waddr      = AW'(sp_q);
      wdata      = cmd_data;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  CMD_PUSH: begin
                     if (sp_q == SP_FULL) begin
                        err_d = 1'b1;
                     end else begin
                        we     = 1'b1;
                        sp_d   = sp_q + SP_ONE;
                        done_d = 1'b1;
                     end
                  end
                  CMD_POP: begin
                     if (sp_q == '0) begin
                        err_d = 1'b1;
                     end else begin
                        sp_d   = sp_q - SP_ONE;
                        done_d = 1'b1;
                     end
                  end
                  CMD_OP: begin
                     if ((sp_q < SP_TWO) || !oper_supported(cmd_oper)) begin
                        err_d = 1'b1;
                     end else begin
                        alu_oper_d = cmd_oper;
                        alu_a_d    = rd_nos;
                        alu_b_d    = rd_tos;
                        state_d    = ST_EXEC;
                     end
                  end
                  default: ;
               endcase
            end
         end
         // done is registered here so it is visible during the WB cycle.
         ST_EXEC: begin
            res_d   = alu_out;
            ovf_n_d = alu_ovf;
            done_d  = 1'b1;
            state_d = ST_WB;
         end
         ST_WB: begin
            we      = 1'b1;
            waddr   = addr_nos;
            wdata   = res_q;
            sp_d    = sp_q - SP_ONE;
            ovf_d   = ovf_n_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sp_q       <= '0;
         alu_oper_q <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         res_q      <= '0;
         ovf_n_q    <= 1'b0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         alu_oper_q <= alu_oper_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         res_q      <= res_d;
         ovf_n_q    <= ovf_n_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign alu_oper = alu_oper_q;
   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign tos      = (sp_q == '0) ? '0 : rd_tos;
   assign depth    = sp_q;
   assign done     = done_q;
   assign err      = err_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_alu_stack_sequencer.sv
// Scoreboard bench for alu_stack_sequencer: a queue-based stack model predicts
// each response; a monitor process checks pulses, latency and resulting state.
module tb_alu_stack_sequencer;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int SP_W  = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = 2'b11;
   logic [3:0]       cmd_oper = '0;
   logic [WIDTH-1:0] cmd_data = '0;
   logic [3:0]       alu_oper;
   logic [WIDTH-1:0] alu_a, alu_b, alu_out;
   logic             alu_ovf;
   logic [WIDTH-1:0] tos;
   logic [SP_W-1:0]  depth;
   logic             done, err, ovf;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_stack_sequencer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_oper  (cmd_oper),
      .cmd_data  (cmd_data),
      .alu_oper  (alu_oper),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_out   (alu_out),
      .alu_ovf   (alu_ovf),
      .tos       (tos),
      .depth     (depth),
      .done      (done),
      .err       (err),
      .ovf       (ovf)
   );

   // Behavioural ALU: {overflow, result}. Add overflow is carry-out, sub is borrow.
   function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         4'd0: return {1'b0, a} + {1'b0, b};
         4'd1: return {a < b, a - b};
         4'd2: return {1'b0, a & b};
         4'd3: return {1'b0, a | b};
         4'd4: return {1'b0, a ^ b};
         4'd5: return {1'b0, a};
         4'd6: return {1'b0, b};
         4'd7: return {1'b0, 16'(a != b)};
         4'd8: return {1'b0, 16'(a != 16'd0)};
         4'd9: return {1'b0, 16'(b < a)};
         default: return '0;
      endcase
   endfunction

   always_comb begin
      logic [16:0] r;
      r       = alu_f(alu_oper, alu_a, alu_b);
      alu_out = r[15:0];
      alu_ovf = r[16];
   end

   typedef struct {
      bit          is_err;
      bit          is_op;
      int          lat;
      int          acc;
      logic [15:0] tos;
      int          depth;
      bit          ovf;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] stk[$];
   bit          ovf_m = 1'b0;
   bit          post_pending = 1'b0;
   exp_t        post_exp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // lat counts clock edges between the accepting edge and the pulse cycle.
   task automatic model_accept(input logic [1:0] op, input logic [3:0] oper, input logic [15:0] data);
      exp_t        e;
      logic [16:0] r;
      logic [15:0] a, b;
      e.is_err = 1'b0;
      e.is_op  = 1'b0;
      e.lat    = 0;
      e.acc    = cyc;
      case (op)
         2'b00: if (stk.size() == DEPTH) e.is_err = 1'b1; else stk.push_back(data);
         2'b01: if (stk.size() == 0) e.is_err = 1'b1; else void'(stk.pop_back());
         2'b10: begin
            if (stk.size() < 2 || oper > 4'd9) begin
               e.is_err = 1'b1;
            end else begin
               b = stk.pop_back();
               a = stk.pop_back();
               r = alu_f(oper, a, b);
               stk.push_back(r[15:0]);
               ovf_m   = r[16];
               e.is_op = 1'b1;
               e.lat   = 1;
            end
         end
         default: return;
      endcase
      e.tos = '0;
      if (stk.size() > 0) e.tos = stk[$];
      e.depth = stk.size();
      e.ovf   = ovf_m;
      sbq.push_back(e);
   endtask

   task automatic send(input logic [1:0] op, input logic [3:0] oper, input logic [15:0] data, output int waits);
      waits = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_oper  = oper;
      cmd_data  = data;
      while (!cmd_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (!cmd_ready) begin
         fail_now("cmd_ready_timeout");
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      model_accept(op, oper, data);
   endtask

   task automatic snd(input logic [1:0] op, input logic [3:0] oper, input logic [15:0] data);
      int w;
      send(op, oper, data, w);
   endtask

   task automatic drain();
      int n = 0;
      while ((sbq.size() != 0 || post_pending) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0 || post_pending) fail_now("drain");
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      sbq.delete();
      stk.delete();
      ovf_m        = 1'b0;
      post_pending = 1'b0;
   endtask

   // Monitor: pops one expectation per done/err pulse.
   initial begin
      exp_t e;
      int   idle = 0;
      forever begin
         @(negedge clk);
         if (reset) continue;
         if (post_pending) begin
            chk("op_tos", 32'(tos), 32'(post_exp.tos));
            chk("op_depth", 32'(depth), 32'(post_exp.depth));
            chk("op_ovf", 32'(ovf), 32'(post_exp.ovf));
            post_pending = 1'b0;
         end
         if (done || err) begin
            chk("done_err_exclusive", 32'(done & err), 32'd0);
            if (sbq.size() == 0) begin
               chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("pulse_is_err", 32'(err), 32'(e.is_err));
               chk("pulse_latency", 32'(cyc - e.acc), 32'(e.lat));
               if (e.is_op && !e.is_err) begin
                  post_exp     = e;
                  post_pending = 1'b1;
               end else begin
                  chk("tos", 32'(tos), 32'(e.tos));
                  chk("depth", 32'(depth), 32'(e.depth));
                  chk("ovf", 32'(ovf), 32'(e.ovf));
               end
            end
            idle = 0;
         end else if (sbq.size() != 0) begin
            idle++;
            if (idle > 20) begin
               fail_now("response_timeout");
               sbq.delete();
               idle = 0;
            end
         end else begin
            idle = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_depth", 32'(depth), 32'd0);
      chk("rst_tos", 32'(tos), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_alu_oper", 32'(alu_oper), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);

      // Test 1/2: add, carry-out overflow, overflow cleared by next add
      snd(2'b00, 4'd0, 16'h0006);
      snd(2'b00, 4'd0, 16'h0009);
      snd(2'b10, 4'd0, 16'h0000);
      drain();
      chk("t1_tos", 32'(tos), 32'h000F);
      chk("t1_depth", 32'(depth), 32'd1);
      chk("t1_ovf", 32'(ovf), 32'd0);
      snd(2'b00, 4'd0, 16'hFFFF);
      snd(2'b00, 4'd0, 16'h0001);
      snd(2'b10, 4'd0, 16'h0000);
      drain();
      chk("t2a_tos", 32'(tos), 32'h0000);
      chk("t2a_ovf", 32'(ovf), 32'd1);
      snd(2'b00, 4'd0, 16'hFFFE);
      snd(2'b00, 4'd0, 16'h0001);
      snd(2'b10, 4'd0, 16'h0000);
      drain();
      chk("t2b_tos", 32'(tos), 32'hFFFF);
      chk("t2b_ovf", 32'(ovf), 32'd0);
      chk("t2b_depth", 32'(depth), 32'd3);

      // Test 3: sub, A!=B, B<A
      do_reset();
      snd(2'b00, 4'd0, 16'hDEAD);
      snd(2'b00, 4'd0, 16'hBEEF);
      snd(2'b10, 4'd1, 16'h0000);
      drain();
      chk("t3_sub", 32'(tos), 32'h1FBE);
      snd(2'b00, 4'd0, 16'h0ABC);
      snd(2'b10, 4'd7, 16'h0000);
      drain();
      chk("t3_neq", 32'(tos), 32'h0001);
      snd(2'b00, 4'd0, 16'hDEAF);
      snd(2'b00, 4'd0, 16'hDEAD);
      snd(2'b10, 4'd9, 16'h0000);
      drain();
      chk("t3_blta", 32'(tos), 32'h0001);
      chk("t3_depth", 32'(depth), 32'd2);

      // Test 4: error cases and full stack
      do_reset();
      snd(2'b01, 4'd0, 16'h0000);
      snd(2'b00, 4'd0, 16'h0005);
      snd(2'b10, 4'd0, 16'h0000);
      snd(2'b00, 4'd0, 16'h0007);
      snd(2'b10, 4'b1100, 16'h0000);
      drain();
      chk("t4_depth", 32'(depth), 32'd2);
      for (int unsigned i = 0; i < DEPTH - 2; i++) snd(2'b00, 4'd0, 16'(32'h0100 + i));
      snd(2'b00, 4'd0, 16'h5555);
      drain();
      chk("t4_full_depth", 32'(depth), 32'(DEPTH));
      chk("t4_full_tos", 32'(tos), 32'(32'h0100 + DEPTH - 3));

      // Test 5: PUSH held across EXEC/WB is accepted exactly once
      snd(2'b10, 4'd4, 16'h0000);
      send(2'b00, 4'd0, 16'h1234, w);
      chk("t5_wait_cycles", 32'(w), 32'd2);
      drain();
      chk("t5_depth", 32'(depth), 32'(DEPTH));
      chk("t5_tos", 32'(tos), 32'h1234);

      // Test 6: reset during EXEC discards the OP
      snd(2'b10, 4'd0, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sbq.delete();
      stk.delete();
      ovf_m = 1'b0;
      @(negedge clk);
      chk("t6_depth", 32'(depth), 32'd0);
      chk("t6_tos", 32'(tos), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_ready", 32'(cmd_ready), 32'd1);

      // Randomized traffic
      for (int unsigned i = 0; i < 400; i++) begin
         int unsigned r, sel;
         logic [15:0] d;
         r   = $urandom_range(0, 9);
         sel = $urandom_range(0, 3);
         d   = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h0000 : 16'($urandom);
         if (r < 4)      snd(2'b00, 4'd0, d);
         else if (r < 6) snd(2'b01, 4'd0, d);
         else if (r < 9) snd(2'b10, 4'($urandom_range(0, 11)), d);
         else            snd(2'b11, 4'd0, d);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drain();
      chk("final_depth", 32'(depth), 32'(stk.size()));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
